// File: rtl/act_stream_fifo_if.sv
// AXI4-Stream beat channel used on both sides of the activation stream FIFO.
// A beat transfers on a rising clk edge where tvalid && tready; the master holds tdata/tkeep/tlast stable while tvalid && !tready.
interface act_stream_fifo_if #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = 8
);
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/act_stream_fifo.sv
// Elastic AXI4-Stream buffer between the activation DMA and the array skew stage; counts stored frames, flags partial TKEEP.
// Define ACT_FIFO_FRAME_GATE_EN for store-and-forward output gating; otherwise the output is cut-through.
module act_stream_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 64,
    parameter int KEEP_W = 8,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    act_stream_fifo_if.slave     s_axis,
    act_stream_fifo_if.master    m_axis,
    output logic [CW-1:0]        level,
    output logic [CW-1:0]        frames_stored,
    output logic                 tkeep_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = DATA_W + KEEP_W + 1;

    logic [BW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] level_q, level_d;
    logic [CW-1:0] frames_q, frames_d;
    logic          tready_q, tready_d;
    logic          err_q, err_d;
    logic          wr_en, rd_en, m_valid, rd_last;

    assign rd_last = mem_q[rd_ptr_q][0];

`ifdef ACT_FIFO_FRAME_GATE_EN
    // Full with no TLAST inside means an oversize frame: release it rather than deadlock.
    assign m_valid = (level_q != '0) && ((frames_q != '0) || (level_q == CW'(DEPTH)));
`else
    assign m_valid = (level_q != '0);
`endif

    assign wr_en = s_axis.tvalid && tready_q && !flush;
    assign rd_en = m_valid && m_axis.tready && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        frames_d = frames_q;
        err_d    = err_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            frames_d = '0;
            err_d    = 1'b0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   level_d = level_q + CW'(1);
                2'b01:   level_d = level_q - CW'(1);
                default: level_d = level_q;
            endcase
            case ({wr_en && s_axis.tlast, rd_en && rd_last})
                2'b10:   frames_d = frames_q + CW'(1);
                2'b01:   frames_d = frames_q - CW'(1);
                default: frames_d = frames_q;
            endcase
            if (wr_en && (s_axis.tkeep != {KEEP_W{1'b1}})) err_d = 1'b1;
        end
        // Registered ready looks at the post-edge level, so a read at full only reopens the input next cycle.
        tready_d = (level_d < CW'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            frames_q <= '0;
            tready_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            frames_q <= frames_d;
            tready_q <= tready_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= {s_axis.tdata, s_axis.tkeep, s_axis.tlast};
    end

    assign s_axis.tready = tready_q;
    assign m_axis.tvalid = m_valid;
    assign m_axis.tdata  = mem_q[rd_ptr_q][BW-1:KEEP_W+1];
    assign m_axis.tkeep  = mem_q[rd_ptr_q][KEEP_W:1];
    assign m_axis.tlast  = rd_last;
    assign level         = level_q;
    assign frames_stored = frames_q;
    assign tkeep_err     = err_q;
endmodule

// File: tb/tb_act_stream_fifo.sv
// Directed bench for act_stream_fifo: a driver pushes expected beats into exp_q, a negedge monitor pops and compares.
module tb_act_stream_fifo;
    localparam int DEPTH  = 16;
    localparam int DATA_W = 64;
    localparam int KEEP_W = 8;
    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int BW     = DATA_W + KEEP_W + 1;
`ifdef ACT_FIFO_FRAME_GATE_EN
    localparam bit GATE = 1'b1;
`else
    localparam bit GATE = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic [CW-1:0] level;
    logic [CW-1:0] frames_stored;
    logic          tkeep_err;

    act_stream_fifo_if #(.DATA_W(DATA_W), .KEEP_W(KEEP_W)) s_axis ();
    act_stream_fifo_if #(.DATA_W(DATA_W), .KEEP_W(KEEP_W)) m_axis ();

    act_stream_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .KEEP_W(KEEP_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .s_axis        (s_axis),
        .m_axis        (m_axis),
        .level         (level),
        .frames_stored (frames_stored),
        .tkeep_err     (tkeep_err)
    );

    always #5 clk = ~clk;

    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] mon_exp, mon_act;
    int n_vec = 0;
    int n_err = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic put(input logic [63:0] d, input logic [7:0] k, input logic l);
        int waited = 0;
        s_axis.tdata  = d;
        s_axis.tkeep  = k;
        s_axis.tlast  = l;
        s_axis.tvalid = 1'b1;
        exp_q.push_back({d, k, l});
        while (!s_axis.tready && waited < 64) begin
            step();
            waited++;
        end
        if (!s_axis.tready) begin
            n_vec++;
            n_err++;
            $display("FAIL put_timeout: beat %0h got no tready expected accept", d);
            void'(exp_q.pop_back());
        end else begin
            step();
        end
        s_axis.tvalid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        m_axis.tready = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin
            step();
            n++;
        end
        chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        m_axis.tready = 1'b0;
    endtask

    // Monitor: every handshake seen at the negedge transfers on the following posedge.
    initial begin
        forever begin
            @(negedge clk);
            if (m_axis.tvalid && m_axis.tready) begin
                mon_act = {m_axis.tdata, m_axis.tkeep, m_axis.tlast};
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_beat: got %0h expected none", mon_act);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_act !== mon_exp) begin
                        n_err++;
                        $display("FAIL beat_data: got %0h expected %0h", mon_act, mon_exp);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        s_axis.tvalid = 1'b0;
        s_axis.tdata  = '0;
        s_axis.tkeep  = '0;
        s_axis.tlast  = 1'b0;
        m_axis.tready = 1'b0;

        // Reset state and ready rising one edge after release
        repeat (2) step();
        chk("rst_tready", s_axis.tready, 0);
        chk("rst_tvalid", m_axis.tvalid, 0);
        chk("rst_level", level, 0);
        chk("rst_frames", frames_stored, 0);
        chk("rst_err", tkeep_err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_tready_before_edge", s_axis.tready, 0);
        step();
        chk("rel_tready_after_edge", s_axis.tready, 1);

        // Three beats streaming straight through
        m_axis.tready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            put(64'h0706050403020100 + 64'(k), 8'hFF, k == 2);
            if (k == 0) chk("t1_latency_valid", m_axis.tvalid, GATE ? 64'd0 : 64'd1);
        end
        drain("t1");
        chk("t1_level", level, 0);
        chk("t1_frames", frames_stored, 0);

        // Fill to DEPTH, 17th beat blocked until one read
        m_axis.tready = 1'b0;
        for (int i = 0; i < 16; i++) put(64'hA000 + 64'(i), 8'hFF, 1'b0);
        chk("t2_tready_full", s_axis.tready, 0);
        chk("t2_level_full", level, 16);
        s_axis.tdata  = 64'hA010;
        s_axis.tkeep  = 8'hFF;
        s_axis.tlast  = 1'b1;
        s_axis.tvalid = 1'b1;
        exp_q.push_back({64'hA010, 8'hFF, 1'b1});
        step();
        chk("t2_level_blocked", level, 16);
        m_axis.tready = 1'b1;
        step();
        m_axis.tready = 1'b0;
        chk("t2_level_after_read", level, 15);
        chk("t2_tready_after_read", s_axis.tready, 1);
        step();
        s_axis.tvalid = 1'b0;
        chk("t2_level_refill", level, 16);
        chk("t2_frames", frames_stored, 1);
        drain("t2");

        // Simultaneous read and write of TLAST beats at level 5
        put(64'hB000, 8'hFF, 1'b1);
        for (int i = 1; i < 5; i++) put(64'hB000 + 64'(i), 8'hFF, 1'b0);
        chk("t3_level_pre", level, 5);
        chk("t3_frames_pre", frames_stored, 1);
        m_axis.tready = 1'b1;
        put(64'hB005, 8'hFF, 1'b1);
        m_axis.tready = 1'b0;
        chk("t3_level", level, 5);
        chk("t3_frames", frames_stored, 1);
        drain("t3");

        // Short frame: output gated until its TLAST lands (gate build)
        m_axis.tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            put(64'hC000 + 64'(i), 8'hFF, i == 3);
            if (i < 3) chk($sformatf("t4_valid_b%0d", i), m_axis.tvalid, GATE ? 64'd0 : 64'd1);
        end
        chk("t4_valid_last", m_axis.tvalid, 1);
        drain("t4");

        // Oversize frame: released once the FIFO fills
        m_axis.tready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            put(64'hD000 + 64'(i), 8'hFF, i == 19);
            if (i == 14) chk("t5_valid_at15", m_axis.tvalid, GATE ? 64'd0 : 64'd1);
            if (i == 15) chk("t5_valid_at16", m_axis.tvalid, 1);
        end
        drain("t5");
        chk("t5_level", level, 0);

        // Partial TKEEP sticky flag, then flush discarding the flush-cycle write
        put(64'hE000, 8'h7F, 1'b1);
        chk("t6_err_set", tkeep_err, 1);
        chk("t6_level", level, 1);
        drain("t6");
        chk("t6_err_sticky", tkeep_err, 1);
        put(64'hE001, 8'hFF, 1'b0);
        void'(exp_q.pop_back());
        s_axis.tdata  = 64'hE002;
        s_axis.tkeep  = 8'hFF;
        s_axis.tlast  = 1'b1;
        s_axis.tvalid = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        s_axis.tvalid = 1'b0;
        chk("t6_flush_err", tkeep_err, 0);
        chk("t6_flush_level", level, 0);
        chk("t6_flush_frames", frames_stored, 0);
        chk("t6_flush_tready", s_axis.tready, 1);
        chk("t6_flush_tvalid", m_axis.tvalid, 0);

        // Asynchronous reset with beats in flight
        for (int i = 0; i < 9; i++) put(64'hF000 + 64'(i), 8'hFF, 1'b0);
        chk("t7_level_pre", level, 9);
        rst_n = 1'b0;
        #1;
        chk("t7_rst_level", level, 0);
        chk("t7_rst_tvalid", m_axis.tvalid, 0);
        chk("t7_rst_tready", s_axis.tready, 0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        chk("t7_tready_at_release", s_axis.tready, 0);
        step();
        chk("t7_tready_after_edge", s_axis.tready, 1);
        put(64'h1234_5678_9ABC_DEF0, 8'hFF, 1'b1);
        drain("t7");
        chk("t7_level_end", level, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/act_stream_fifo.md
# act_stream_fifo

AXI4-Stream elastic buffer that sits directly upstream of the activation input interface, between the activation DMA and the systolic-array skew stage. It absorbs DMA burstiness while the input interface accepts only one beat per spatial position, stores 64-bit beats (8 × INT8 activations) with TKEEP and TLAST, and tracks how many complete frames it holds. It also flags malformed beats.

## Interface

- DEPTH, 16, beat storage entries; power of two, ≥ 2
- DATA_W, AXI_DATA_WIDTH (64), beat width
- KEEP_W, AXI_KEEP_WIDTH (8), TKEEP width
- CW, $clog2(DEPTH)+1, counter width (derived, not overridable)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous clear of contents, counters and error flag
- s_axis_tdata  in  DATA_W  beat from DMA
- s_axis_tkeep  in  KEEP_W  byte enables, stored and forwarded
- s_axis_tvalid  in  1  upstream valid
- s_axis_tready  out  1  registered; high when not full
- s_axis_tlast  in  1  last beat of frame
- m_axis_tdata  out  DATA_W  head beat to input interface
- m_axis_tkeep  out  KEEP_W  head beat TKEEP
- m_axis_tvalid  out  1  head beat available (subject to frame gate)
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  head beat TLAST
- level  out  CW  beats stored, 0..DEPTH
- frames_stored  out  CW  TLAST beats stored, 0..DEPTH
- tkeep_err  out  1  sticky: a beat with TKEEP ≠ all-ones was accepted

## Operation

- Write when s_axis_tvalid && s_axis_tready: store {tdata, tkeep, tlast} at wr_ptr, wr_ptr++ mod DEPTH.
- Read when m_axis_tvalid && m_axis_tready: rd_ptr++ mod DEPTH.
- Pointers are log2(DEPTH) bits; wrap is natural overflow. Full/empty derive from level, not from pointer compare.
- level: +1 on write only, −1 on read only, unchanged on both.
- frames_stored: +1 on write with tlast, −1 on read with tlast, unchanged when both occur in the same cycle.
- m_axis_tdata/tkeep/tlast are driven from storage at rd_ptr. They are stable while tvalid && !tready.
- tkeep_err: set on any accepted write with tkeep ≠ {KEEP_W{1'b1}}. The beat is still stored. Cleared only by flush or reset.
- flush: next edge sets pointers, level, frames_stored and tkeep_err to 0, and s_axis_tready to 1. Any write or read in the flush cycle is discarded. Storage contents are don't-care.

## Timing

- Reset values: s_axis_tready=0, m_axis_tvalid=0, level=0, frames_stored=0, tkeep_err=0. m_axis_tdata/tkeep/tlast are don't-care while tvalid=0.
- s_axis_tready rises on the first clk edge after rst_n deasserts.
- s_axis_tready is registered: next value = (next level < DEPTH).
- At full, a same-cycle read does not permit a write. tready returns high the cycle after the read.
- Latency is one cycle, with no bypass. A beat written at edge N is visible on m_axis at N+1, including into an empty FIFO.
- Sustained throughput is 1 beat/cycle when level is between 1 and DEPTH−1.
- If rst_n asserts mid-transfer, all state clears immediately and in-flight beats are lost.

## Configuration

- ACT_FIFO_FRAME_GATE_EN defined: store-and-forward. m_axis_tvalid = (level≠0) && (frames_stored≠0 || level==DEPTH).
  - The level==DEPTH term is the oversize-frame release: a frame longer than DEPTH is streamed cut-through once the FIFO fills, avoiding deadlock.
- ACT_FIFO_FRAME_GATE_EN undefined: cut-through. m_axis_tvalid = (level≠0). frames_stored is still maintained.

## Test plan

- Reset, then write 3 beats 0x0706050403020100+k (k=0..2, last has tlast), m_axis_tready=1 → beats emerge in order one cycle after each write; final level=0, frames_stored=0.
- m_axis_tready=0, 17 writes offered with DEPTH=16 → 16 accepted, s_axis_tready=0 after the 16th, level=16. One read → s_axis_tready=1 next cycle, then the 17th beat is accepted.
- Simultaneous read and write at level=5, with a tlast beat in and a tlast beat out → level=5, frames_stored unchanged.
- Gate enabled: 4-beat frame written with tlast on beat 4 → m_axis_tvalid stays 0 until the cycle after beat 4 is written. 20-beat frame (no tlast in first 16) → tvalid rises when level hits 16 and the frame drains fully.
- Beat with tkeep=8'h7F → tkeep_err=1 next cycle, beat forwarded with tkeep=8'h7F. flush → tkeep_err=0, level=0.
- rst_n pulsed low with level=9 → level=0, m_axis_tvalid=0, s_axis_tready=0 immediately; s_axis_tready=1 one edge after release.
